// File: rtl/video_stream_sink.sv
// Avalon-ST 30-bit RGB pixel sink: checks SOP/EOP framing, reduces pixels to RGB444
// and writes them at raster addresses into a 12-bit frame buffer write port.
module video_stream_sink #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [29:0]       snk_data,
    input  logic              snk_valid,
    input  logic              snk_startofpacket,
    input  logic              snk_endofpacket,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] wr_address,
    output logic [11:0]       wr_data,
    output logic              wr_en,
    output logic              frame_done,
    output logic              frame_error,
    output logic [15:0]       frame_count,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pix, w_pix_nxt;
    logic [ADDR_W-1:0]   w_addr;
    logic                r_ready;
    logic                w_accept, w_wr, w_done, w_err;
    logic [11:0]         r_wr_data;
    logic [ADDR_W-1:0]   r_wr_address;
    logic                r_wr_en, r_done, r_err;
    logic [15:0]         r_frame_count;
    logic [7:0]          r_err_count;
    logic                w_unused;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [11:0] to_rgb444(input logic [29:0] d);
        return {d[29:26], d[19:16], d[9:6]};
    endfunction

    assign w_unused = ^{snk_data[25:20], snk_data[15:10], snk_data[5:0]};
    assign w_accept = snk_valid & r_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pix_nxt   = r_pix;
        w_addr      = '0;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (w_accept) begin
            if (snk_startofpacket) begin
                // SOP always restarts at pixel 0, whatever state we were in
                w_wr = 1'b1;
                if (snk_endofpacket) begin
                    w_done      = (r_state != S_RECV) && (LAST == '0);
                    w_err       = !w_done;
                    w_state_nxt = S_IDLE;
                    w_pix_nxt   = '0;
                end else begin
                    w_err       = (r_state == S_RECV);
                    w_state_nxt = S_RECV;
                    w_pix_nxt   = ADDR_W'(1);
                end
            end else if (r_state == S_RECV) begin
                w_wr   = 1'b1;
                w_addr = r_pix;
                if (snk_endofpacket) begin
                    w_done      = (r_pix == LAST);
                    w_err       = (r_pix != LAST);
                    w_state_nxt = S_IDLE;
                    w_pix_nxt   = '0;
                end else if (r_pix == LAST) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_DISCARD;
                    w_pix_nxt   = '0;
                end else begin
                    w_pix_nxt = r_pix + ADDR_W'(1);
                end
            end else if (r_state == S_DISCARD && snk_endofpacket) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pix         <= '0;
            r_ready       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_address  <= '0;
            r_wr_data     <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pix   <= w_pix_nxt;
            r_ready <= en;
            r_wr_en <= w_wr;
            r_done  <= w_done;
            r_err   <= w_err;
            if (w_wr) begin
                r_wr_address <= w_addr;
                r_wr_data    <= to_rgb444(snk_data);
            end
            if (w_done) r_frame_count <= r_frame_count + 16'd1;
            if (w_err)  r_err_count   <= sat_inc8(r_err_count);
        end
    end

    assign snk_ready   = r_ready;
    assign wr_en       = r_wr_en;
    assign wr_address  = r_wr_address;
    assign wr_data     = r_wr_data;
    assign frame_done  = r_done;
    assign frame_error = r_err;
    assign frame_count = r_frame_count;
    assign err_count   = r_err_count;

endmodule
